// File: rtl/mc_controller_if.sv
// Bundle between the multicycle controller and the datapath/memory side:
// instruction fields, ALU flags and memory handshake in; control strobes out.
interface mc_controller_if #(parameter int BE_W = 4);
  logic [3:0]      Cond;
  logic [1:0]      Op;
  logic [5:0]      Funct;
  logic [3:0]      Rd;
  logic [1:0]      Op2;
  logic [1:0]      ByteSel;
  logic [3:0]      ALUFlags;
  logic            mem_ready;

  logic            PCWrite;
  logic            AdrSrc;
  logic            IRWrite;
  logic            RegW;
  logic            MemW;
  logic            mem_req;
  logic            ALUSrcA;
  logic            ShifterSrc;
  logic            mem_err;
  logic [1:0]      ResultSrc;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ImmSrc;
  logic [1:0]      RegSrc;
  logic [3:0]      ALUControl;
  logic [BE_W-1:0] be;

  modport master (
    input  Cond, Op, Funct, Rd, Op2, ByteSel, ALUFlags, mem_ready,
    output PCWrite, AdrSrc, IRWrite, RegW, MemW, mem_req, ALUSrcA, ShifterSrc,
           mem_err, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, be
  );

  modport slave (
    output Cond, Op, Funct, Rd, Op2, ByteSel, ALUFlags, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, RegW, MemW, mem_req, ALUSrcA, ShifterSrc,
           mem_err, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, be
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-style controller with memory wait timeout and byte enables.
// Define MC_CTRL_BL_EN to add the BLINK state (BL writes R14); otherwise BL runs as B.
module mc_controller #(
  parameter int BE_W         = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic            clk,
  input logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
`ifdef MC_CTRL_BL_EN
    , BLINK
`endif
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            condex;
  logic [3:0]      flags;
  logic [7:0]      wait_cnt;
  logic            mem_err_q;
  logic [BE_W-1:0] be_q;
  logic [BE_W-1:0] be_dec;
  logic [3:0]      be_sub;
  logic            be_word;
  logic            is_load;
  logic            mem_phase;
  logic            timeout;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return cy;
      4'b0011: return !cy;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return cy && !z;
      4'b1001: return !cy || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Only arithmetic ops produce meaningful carry/overflow.
  function automatic logic cv_update(input logic [3:0] alu);
    case (alu)
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign is_load   = (bus.Op == 2'b01 && bus.Funct[0]) ||
                     (bus.Op == 2'b00 && bus.Op2 != 2'b00 && bus.Funct[5]);
  assign mem_phase = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // A ready arriving on the limit cycle still completes the access.
  assign timeout   = mem_phase && !bus.mem_ready && (wait_cnt == 8'(MEM_WAIT_MAX));

  always_comb begin
    be_sub  = 4'b0000;
    be_word = 1'b0;
    if (bus.Op == 2'b01) begin
      if (bus.Funct[2]) be_sub = {2'b00, bus.ByteSel};
      else              be_word = 1'b1;
    end else begin
      case (bus.Op2)
        2'b01:   be_sub = bus.Funct[5] ? {2'b01, bus.ByteSel} : 4'b0100;
        2'b10:   be_sub = {2'b10, bus.ByteSel};
        2'b11:   be_sub = {2'b11, bus.ByteSel[1], 1'b0};
        default: be_word = 1'b1;
      endcase
    end
    be_dec = be_word ? {BE_W{1'b1}} : BE_W'(be_sub);
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (bus.mem_ready) state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_next = (bus.Op2 != 2'b00) ? MEMADR : (bus.Funct[5] ? EXECI : EXECR);
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = is_load ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) state_next = MEMWB;
      MEMWR:  if (bus.mem_ready) state_next = FETCH;
      EXECR,
      EXECI:  state_next = ALUWB;
`ifdef MC_CTRL_BL_EN
      BRANCH: state_next = bus.Funct[4] ? BLINK : FETCH;
`else
      BRANCH: state_next = FETCH;
`endif
      default: state_next = FETCH;
    endcase
    if (timeout) state_next = FETCH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      condex    <= 1'b0;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
      be_q      <= '0;
    end else begin
      state     <= state_next;
      mem_err_q <= timeout;
      if (state_next != state || timeout) wait_cnt <= 8'd0;
      else if (mem_phase && !bus.mem_ready) wait_cnt <= wait_cnt + 8'd1;
      if (state == DECODE) condex <= cond_eval(bus.Cond, flags);
      if ((state == EXECR || state == EXECI) && condex && bus.Funct[0]) begin
        flags[3:2] <= bus.ALUFlags[3:2];
        if (cv_update(bus.Funct[4:1])) flags[1:0] <= bus.ALUFlags[1:0];
      end
      // Byte enables are captured once on entry to MEMADR and held for the access.
      if (state_next == MEMADR || state_next == MEMRD || state_next == MEMWB || state_next == MEMWR)
        be_q <= (state == DECODE) ? be_dec : be_q;
      else
        be_q <= '0;
    end
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.mem_req    = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ShifterSrc = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ImmSrc     = 2'b00;
    bus.RegSrc     = 2'b00;
    bus.ALUControl = 4'b0000;
    case (state)
      FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWrite   = 1'b1;
          bus.PCWrite   = 1'b1;
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
        end
      end
      MEMADR: begin
        bus.ALUControl = 4'b0100;
        bus.ALUSrcB    = 2'b01;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      MEMWR: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
        bus.MemW    = condex;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = condex;
      end
      EXECR, EXECI: begin
        bus.ALUControl = bus.Funct[4:1];
        bus.ShifterSrc = (bus.Funct[4:1] == 4'b1101);
        bus.ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
      end
      ALUWB: begin
        bus.RegW    = condex && (bus.Funct[4:3] != 2'b10);
        bus.PCWrite = condex && (bus.Funct[4:3] != 2'b10) && (bus.Rd == 4'b1111);
      end
      BRANCH: begin
        bus.ImmSrc  = 2'b10;
        bus.RegSrc  = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = condex;
      end
`ifdef MC_CTRL_BL_EN
      BLINK: begin
        bus.RegW      = condex;
        bus.ResultSrc = 2'b10;
      end
`endif
      default: ;
    endcase
    // Architectural writes are held off for as long as reset is asserted.
    if (!reset) begin
      bus.PCWrite = 1'b0;
      bus.IRWrite = 1'b0;
      bus.RegW    = 1'b0;
      bus.MemW    = 1'b0;
    end
  end

  assign bus.be      = be_q;
  assign bus.mem_err = mem_err_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction transaction model (cycle count, write
// strobes, byte enables, timeouts, flag-driven conditions) checked on randomized and directed instructions.
module tb_mc_controller;
  localparam int BE_W = 4;
  localparam int WMAX = 4;
`ifdef MC_CTRL_BL_EN
  localparam bit BL_EN = 1'b1;
`else
  localparam bit BL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   mn, mz, mc, mv;

  mc_controller_if #(.BE_W(BE_W)) bus ();
  mc_controller #(.BE_W(BE_W), .MEM_WAIT_MAX(WMAX)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c);
    case (c)
      4'd0:  return mz;
      4'd1:  return !mz;
      4'd2:  return mc;
      4'd3:  return !mc;
      4'd4:  return mn;
      4'd5:  return !mn;
      4'd6:  return mv;
      4'd7:  return !mv;
      4'd8:  return mc && !mz;
      4'd9:  return !mc || mz;
      4'd10: return mn == mv;
      4'd11: return mn != mv;
      4'd12: return !mz && (mn == mv);
      4'd13: return mz || (mn != mv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int wen();
    return int'({bus.RegW, bus.MemW, bus.PCWrite, bus.IRWrite});
  endfunction

  // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input string name, input logic [3:0] cond, input logic [1:0] op,
      input logic [5:0] funct, input logic [3:0] rd, input logic [1:0] op2,
      input logic [1:0] bsel, input logic [3:0] aflags, input int fdly, input int ddly);
    bit pass, is_mem, is_load, is_dp, is_br, is_bl, timed, exp_regw, exp_sh;
    int post, exp_cyc, exp_memw, exp_pcw, exp_alu, exp_imm;
    logic [3:0] exp_be;
    int idx, facc, dacc, fetch_end, regw_n, regw_at, memw_n, pcw_n, irw_n, be_bad, err_n;
    int alu_at, imm_at, sh_at;
    bit fetched, rdy, done;

    pass     = cond_ok(cond);
    is_br    = (op == 2'b10);
    is_mem   = (op == 2'b01) || (op == 2'b00 && op2 != 2'b00);
    is_dp    = (op == 2'b00) && !is_mem;
    is_load  = (op == 2'b01 && funct[0]) || (op == 2'b00 && op2 != 2'b00 && funct[5]);
    is_bl    = is_br && funct[4] && BL_EN;
    timed    = is_mem && (ddly > WMAX);
    if (is_dp)       post = 3;
    else if (is_br)  post = is_bl ? 3 : 2;
    else if (is_mem) post = timed ? 2 + WMAX + 1 : 2 + ddly + 1 + (is_load ? 1 : 0);
    else             post = 1;
    exp_cyc  = fdly + 1 + post;
    exp_regw = pass && ((is_dp && funct[4:3] != 2'b10) || (is_load && !timed) || is_bl);
    exp_memw = (is_mem && !is_load && pass) ? (timed ? WMAX + 1 : ddly + 1) : 0;
    exp_pcw  = 1 + ((is_dp && exp_regw && rd == 4'hF) ? 1 : 0) + ((is_br && pass) ? 1 : 0);
    exp_alu  = is_dp ? int'(funct[4:1]) : (is_mem ? 4 : 0);
    exp_imm  = is_br ? 2 : 0;
    exp_sh   = is_dp && (funct[4:1] == 4'b1101);
    if (op == 2'b01)     exp_be = funct[2] ? {2'b00, bsel} : 4'b1111;
    else if (op2 == 2'b01) exp_be = funct[5] ? {2'b01, bsel} : 4'b0100;
    else if (op2 == 2'b10) exp_be = {2'b10, bsel};
    else                   exp_be = {2'b11, bsel[1], 1'b0};

    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    bus.Op2 = op2; bus.ByteSel = bsel; bus.ALUFlags = aflags;
    idx = 0; facc = 0; dacc = 0; fetch_end = 0; fetched = 0; done = 0;
    regw_n = 0; regw_at = -1; memw_n = 0; pcw_n = 0; irw_n = 0; be_bad = 0; err_n = 0;
    alu_at = 0; imm_at = 0; sh_at = 0;
    while (!done && idx < 64) begin
      if (!fetched && bus.mem_req && !bus.AdrSrc) begin rdy = (facc == fdly); facc++; end
      else if (fetched && bus.mem_req && bus.AdrSrc) begin rdy = (dacc == ddly); dacc++; end
      else rdy = 1'($urandom_range(0, 1));
      bus.mem_ready = rdy;
      @(negedge clk);
      if (bus.RegW) begin regw_n++; regw_at = idx; end
      memw_n += int'(bus.MemW);
      pcw_n  += int'(bus.PCWrite);
      irw_n  += int'(bus.IRWrite);
      if (idx > 0 && bus.mem_err) err_n++;
      if (bus.be !== ((is_mem && fetched && idx >= fetch_end + 2) ? exp_be : 4'h0)) be_bad++;
      if (fetched && idx == fetch_end + 2) begin
        alu_at = int'(bus.ALUControl); imm_at = int'(bus.ImmSrc); sh_at = int'(bus.ShifterSrc);
      end
      if (!fetched && bus.IRWrite) begin fetched = 1; fetch_end = idx; end
      @(posedge clk); #1;
      idx++;
      done = fetched && (idx >= fetch_end + 2) && bus.mem_req && !bus.AdrSrc;
    end

    check($sformatf("%s.done", name), int'(done), 1);
    check($sformatf("%s.cycles", name), idx, exp_cyc);
    check($sformatf("%s.regw_n", name), regw_n, exp_regw ? 1 : 0);
    check($sformatf("%s.regw_at", name), regw_at, exp_regw ? exp_cyc - 1 : -1);
    check($sformatf("%s.memw_n", name), memw_n, exp_memw);
    check($sformatf("%s.pcw_n", name), pcw_n, exp_pcw);
    check($sformatf("%s.irw_n", name), irw_n, 1);
    check($sformatf("%s.be_bad", name), be_bad, 0);
    check($sformatf("%s.err_in", name), err_n, 0);
    check($sformatf("%s.alu", name), alu_at, exp_alu);
    check($sformatf("%s.imm", name), imm_at, exp_imm);
    check($sformatf("%s.shsrc", name), sh_at, int'(exp_sh));
    check($sformatf("%s.mem_err", name), int'(bus.mem_err), int'(timed));

    if (is_dp && pass && funct[0]) begin
      mn = aflags[3]; mz = aflags[2];
      if (funct[4:1] inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11}) begin
        mc = aflags[1]; mv = aflags[0];
      end
    end
  endtask

  initial begin
    int k;
    logic [1:0] rop, rop2;
    logic [3:0] rcond;
    reset = 1'b0; bus.mem_ready = 1'b1;
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0;
    bus.Op2 = 2'b00; bus.ByteSel = 2'b00; bus.ALUFlags = 4'd0;
    mn = 0; mz = 0; mc = 0; mv = 0;

    // Reset held for two edges with mem_ready high: FETCH must not write.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.wen", wen(), 0);
    check("rst.mem_req", int'(bus.mem_req), 1);
    check("rst.be", int'(bus.be), 0);
    check("rst.mem_err", int'(bus.mem_err), 0);
    @(posedge clk); #1;
    reset = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    check("post_rst.mem_req", int'(bus.mem_req), 1);
    check("post_rst.wen", wen(), 0);
    @(posedge clk); #1;

    run_instr("add",      4'hE, 2'b00, 6'b001000, 4'd1, 2'b00, 2'b00, 4'b0000, 0, 0);
    run_instr("ldrsh",    4'hE, 2'b00, 6'b100001, 4'd3, 2'b11, 2'b11, 4'b0000, 1, 3);
    run_instr("subs",     4'hE, 2'b00, 6'b000101, 4'd0, 2'b00, 2'b00, 4'b0110, 0, 0);
    run_instr("bne",      4'h1, 2'b10, 6'b100000, 4'd0, 2'b00, 2'b00, 4'b0000, 0, 0);
    run_instr("beq",      4'h0, 2'b10, 6'b100000, 4'd0, 2'b00, 2'b00, 4'b0000, 0, 0);
    run_instr("str_to",   4'hE, 2'b01, 6'b011000, 4'd4, 2'b00, 2'b00, 4'b0000, 0, 9);
    run_instr("strb_edge",4'hE, 2'b01, 6'b011100, 4'd5, 2'b00, 2'b10, 4'b0000, 2, WMAX);
    run_instr("ldrb_to",  4'hE, 2'b01, 6'b011101, 4'd6, 2'b00, 2'b01, 4'b0000, 0, WMAX + 1);
    run_instr("bl",       4'hE, 2'b10, 6'b110000, 4'd0, 2'b00, 2'b00, 4'b0000, 0, 0);
    run_instr("undef",    4'hE, 2'b11, 6'b111111, 4'hF, 2'b00, 2'b00, 4'b1111, 0, 0);
    run_instr("mov_pc",   4'hE, 2'b00, 6'b111010, 4'hF, 2'b00, 2'b00, 4'b0000, 0, 0);

    // Reset in the middle of a load wait.
    bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd2;
    bus.Op2 = 2'b00; bus.ByteSel = 2'b00; bus.mem_ready = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      k++;
    end while (!(bus.mem_req && bus.AdrSrc) && k < 8);
    check("rstmid.reach_memrd", int'(bus.mem_req && bus.AdrSrc), 1);
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    check("rstmid.wen_during", wen(), 0);
    @(posedge clk); #1;
    reset = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rstmid.mem_req", int'(bus.mem_req), 1);
    check("rstmid.adrsrc", int'(bus.AdrSrc), 0);
    check("rstmid.wen_after", wen(), 0);
    check("rstmid.be", int'(bus.be), 0);
    check("rstmid.mem_err", int'(bus.mem_err), 0);
    mn = 0; mz = 0; mc = 0; mv = 0;
    @(posedge clk); #1;
    run_instr("beq_post_rst", 4'h0, 2'b10, 6'b100000, 4'd0, 2'b00, 2'b00, 4'b0000, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rcond = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rop   = 2'($urandom_range(0, 3));
      rop2  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      run_instr($sformatf("r%0d", i), rcond, rop, 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)), rop2, 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
